// File: rtl/mips_pkg.sv
// Shared register-file and latency constants for the decode-stage hazard logic.
package mips_pkg;
  localparam int unsigned REG_W = 3;
  localparam int unsigned NREGS = 8;
  localparam int unsigned LAT_W = 2;

  localparam logic [LAT_W-1:0] LAT_ALU  = 2'd0;
  localparam logic [LAT_W-1:0] LAT_LOAD = 2'd1;
  localparam logic [LAT_W-1:0] LAT_MUL  = 2'd2;
endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-stage <-> scoreboard signal bundle; stall_cnt exists only with HAZARD_SCOREBOARD_STALL_CNT_EN.
interface hazard_scoreboard_if;
  import mips_pkg::*;

  logic               id_valid;
  logic               id_use1;
  logic               id_use2;
  logic [REG_W-1:0]   id_rsrc1;
  logic [REG_W-1:0]   id_rsrc2;
  logic               id_wr;
  logic [REG_W-1:0]   id_rdst;
  logic [LAT_W-1:0]   id_lat;
  logic               flush;
  logic               stall;
  logic [NREGS-1:0]   pending;
`ifdef HAZARD_SCOREBOARD_STALL_CNT_EN
  logic [15:0]        stall_cnt;

  modport master (
    output id_valid, id_use1, id_use2, id_rsrc1, id_rsrc2, id_wr, id_rdst, id_lat, flush,
    input  stall, pending, stall_cnt
  );
  modport slave (
    input  id_valid, id_use1, id_use2, id_rsrc1, id_rsrc2, id_wr, id_rdst, id_lat, flush,
    output stall, pending, stall_cnt
  );
`else
  modport master (
    output id_valid, id_use1, id_use2, id_rsrc1, id_rsrc2, id_wr, id_rdst, id_lat, flush,
    input  stall, pending
  );
  modport slave (
    input  id_valid, id_use1, id_use2, id_rsrc1, id_rsrc2, id_wr, id_rdst, id_lat, flush,
    output stall, pending
  );
`endif
endinterface

// File: rtl/hazard_scoreboard_sb_entry.sv
// One register's forwarding-readiness countdown: load wins over decrement, saturates at zero.
module sb_entry
  import mips_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [LAT_W-1:0] i_lat,
  output logic [LAT_W-1:0] o_cnt
);
  logic [LAT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= i_lat;
    else if (r_cnt != '0)
      r_cnt <= r_cnt - 1'b1;
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register latency scoreboard producing decode stall; optional stall counter
// enabled by HAZARD_SCOREBOARD_STALL_CNT_EN.
module hazard_scoreboard
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  hazard_scoreboard_if.slave sb
);
  logic [LAT_W-1:0] w_cnt [NREGS];
  logic [NREGS-1:0] w_load;
  logic [NREGS-1:0] w_pending;
  logic             w_hazard;
  logic             w_stall;
  logic             w_accept;

  for (genvar g = 0; g < NREGS; g++) begin : g_entry
    assign w_load[g] = w_accept && sb.id_wr && (sb.id_rdst == REG_W'(g));

    sb_entry u_entry (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_load[g]),
      .i_lat  (sb.id_lat),
      .o_cnt  (w_cnt[g])
    );
  end

  // WAW: an older write still outstanding longer than the new one would land last.
  always_comb begin
    w_hazard = (sb.id_use1 && (w_cnt[sb.id_rsrc1] != '0))
            || (sb.id_use2 && (w_cnt[sb.id_rsrc2] != '0))
            || (sb.id_wr   && (w_cnt[sb.id_rdst] > sb.id_lat));
    w_stall  = sb.id_valid && !sb.flush && w_hazard;
    w_accept = sb.id_valid && !sb.flush && !w_hazard;
  end

  always_comb begin
    w_pending = '0;
    for (int unsigned i = 0; i < NREGS; i++)
      w_pending[i] = (w_cnt[i] != '0);
  end

  assign sb.stall   = w_stall;
  assign sb.pending = w_pending;

`ifdef HAZARD_SCOREBOARD_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_stall_cnt <= '0;
    else if (w_stall && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign sb.stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scenario bench for hazard_scoreboard: per-cycle expectations queued at drive time, checked before the edge.
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  hazard_scoreboard_if bus();

  hazard_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .sb  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, v, u1, u2, wr, fl;
    logic [2:0] rs1, rs2, rd;
    logic [1:0] lat;
    logic       es;
    logic [7:0] ep;
  } step_t;

  typedef struct {
    logic       stall;
    logic [7:0] pend;
  } exp_t;

  exp_t sb_q[$];

  function automatic step_t mk(input logic r, input logic v, input logic u1, input logic [2:0] rs1,
                               input logic u2, input logic [2:0] rs2, input logic wr,
                               input logic [2:0] rd, input logic [1:0] lat, input logic fl,
                               input logic es, input logic [7:0] ep);
    step_t s;
    s.rst = r; s.v = v; s.u1 = u1; s.rs1 = rs1; s.u2 = u2; s.rs2 = rs2;
    s.wr = wr; s.rd = rd; s.lat = lat; s.fl = fl; s.es = es; s.ep = ep;
    return s;
  endfunction

  function automatic step_t idle(input logic [7:0] ep);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ep);
  endfunction

  task automatic drive_step(input step_t s);
    exp_t e;
    @(negedge clk);
    rst          = s.rst;
    bus.id_valid = s.v;
    bus.id_use1  = s.u1;
    bus.id_rsrc1 = s.rs1;
    bus.id_use2  = s.u2;
    bus.id_rsrc2 = s.rs2;
    bus.id_wr    = s.wr;
    bus.id_rdst  = s.rd;
    bus.id_lat   = s.lat;
    bus.flush    = s.fl;
    e.stall = s.es;
    e.pend  = s.ep;
    sb_q.push_back(e);
    #1;
  endtask

  task automatic test_reset();
    step_t st[$];
    exp_t  e;
    rst = 1'b1;
    bus.id_valid = 1'b0; bus.id_use1 = 1'b0; bus.id_use2 = 1'b0; bus.id_wr = 1'b0; bus.flush = 1'b0;
    bus.id_rsrc1 = '0; bus.id_rsrc2 = '0; bus.id_rdst = '0; bus.id_lat = '0;
    repeat (2) @(posedge clk);
    st.push_back(mk(1, 1, 1, 5, 0, 0, 1, 3, 3, 0, 0, 8'h00));
    st.push_back(idle(8'h00));
    foreach (st[i]) begin
      drive_step(st[i]);
      e = sb_q.pop_front();
      total++;
      if (bus.stall !== e.stall || bus.pending !== e.pend) begin
        bad++;
        $display("FAIL reset step %0d: stall=%b pending=%h expected stall=%b pending=%h",
                 i, bus.stall, bus.pending, e.stall, e.pend);
      end
    end
`ifdef HAZARD_SCOREBOARD_STALL_CNT_EN
    total++;
    if (bus.stall_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset stall_cnt: got %0d expected 0", bus.stall_cnt);
    end
`endif
  endtask

  task automatic test_multi_cycle();
    step_t st[$];
    exp_t  e;
    st.push_back(mk(0, 1, 0, 0, 0, 0, 1, 5, 3, 0, 0, 8'h00));
    st.push_back(mk(0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 1, 8'h20));
    st.push_back(mk(0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 1, 8'h20));
    st.push_back(mk(0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 1, 8'h20));
    st.push_back(mk(0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    st.push_back(idle(8'h00));
    foreach (st[i]) begin
      drive_step(st[i]);
      e = sb_q.pop_front();
      total++;
      if (bus.stall !== e.stall || bus.pending !== e.pend) begin
        bad++;
        $display("FAIL multi step %0d: stall=%b pending=%h expected stall=%b pending=%h",
                 i, bus.stall, bus.pending, e.stall, e.pend);
      end
    end
`ifdef HAZARD_SCOREBOARD_STALL_CNT_EN
    total++;
    if (bus.stall_cnt !== 16'd3) begin
      bad++;
      $display("FAIL multi stall_cnt: got %0d expected 3", bus.stall_cnt);
    end
`endif
  endtask

  task automatic test_load_use();
    step_t st[$];
    exp_t  e;
    st.push_back(mk(0, 1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 8'h00));
    st.push_back(mk(0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 1, 8'h08));
    st.push_back(mk(0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    st.push_back(idle(8'h00));
    foreach (st[i]) begin
      drive_step(st[i]);
      e = sb_q.pop_front();
      total++;
      if (bus.stall !== e.stall || bus.pending !== e.pend) begin
        bad++;
        $display("FAIL load_use step %0d: stall=%b pending=%h expected stall=%b pending=%h",
                 i, bus.stall, bus.pending, e.stall, e.pend);
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t st[$];
    exp_t  e;
    st.push_back(mk(0, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 8'h00));
    st.push_back(mk(0, 1, 0, 0, 1, 2, 1, 1, 0, 0, 0, 8'h00));
    st.push_back(mk(0, 1, 1, 1, 1, 2, 0, 0, 0, 0, 0, 8'h00));
    st.push_back(idle(8'h00));
    foreach (st[i]) begin
      drive_step(st[i]);
      e = sb_q.pop_front();
      total++;
      if (bus.stall !== e.stall || bus.pending !== e.pend) begin
        bad++;
        $display("FAIL back_to_back step %0d: stall=%b pending=%h expected stall=%b pending=%h",
                 i, bus.stall, bus.pending, e.stall, e.pend);
      end
    end
  endtask

  task automatic test_waw();
    step_t st[$];
    exp_t  e;
    st.push_back(mk(0, 1, 0, 0, 0, 0, 1, 4, 3, 0, 0, 8'h00));
    st.push_back(mk(0, 1, 0, 0, 0, 0, 1, 4, 0, 0, 1, 8'h10));
    st.push_back(mk(0, 1, 0, 0, 0, 0, 1, 4, 0, 0, 1, 8'h10));
    st.push_back(mk(0, 1, 0, 0, 0, 0, 1, 4, 0, 0, 1, 8'h10));
    st.push_back(mk(0, 1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 8'h00));
    st.push_back(mk(0, 1, 0, 0, 0, 0, 1, 4, 1, 0, 0, 8'h00));
    // cnt[4]=1 and new lat=1: equal latency is not a WAW hazard
    st.push_back(mk(0, 1, 0, 0, 0, 0, 1, 4, 1, 0, 0, 8'h10));
    st.push_back(mk(0, 1, 0, 0, 0, 0, 1, 4, 0, 0, 1, 8'h10));
    st.push_back(mk(0, 1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 8'h00));
    st.push_back(idle(8'h00));
    foreach (st[i]) begin
      drive_step(st[i]);
      e = sb_q.pop_front();
      total++;
      if (bus.stall !== e.stall || bus.pending !== e.pend) begin
        bad++;
        $display("FAIL waw step %0d: stall=%b pending=%h expected stall=%b pending=%h",
                 i, bus.stall, bus.pending, e.stall, e.pend);
      end
    end
  endtask

  task automatic test_flush();
    step_t st[$];
    exp_t  e;
    st.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 2, 0, 0, 8'h00));
    st.push_back(mk(0, 1, 1, 1, 0, 0, 1, 7, 3, 1, 0, 8'h02));
    st.push_back(idle(8'h02));
    st.push_back(idle(8'h00));
    foreach (st[i]) begin
      drive_step(st[i]);
      e = sb_q.pop_front();
      total++;
      if (bus.stall !== e.stall || bus.pending !== e.pend) begin
        bad++;
        $display("FAIL flush step %0d: stall=%b pending=%h expected stall=%b pending=%h",
                 i, bus.stall, bus.pending, e.stall, e.pend);
      end
    end
  endtask

  task automatic test_reset_mid();
    step_t st[$];
    exp_t  e;
    st.push_back(mk(0, 1, 0, 0, 0, 0, 1, 6, 2, 0, 0, 8'h00));
    st.push_back(mk(1, 1, 1, 6, 0, 0, 1, 0, 3, 0, 1, 8'h40));
    st.push_back(mk(0, 1, 1, 6, 0, 0, 1, 2, 3, 0, 0, 8'h00));
    st.push_back(idle(8'h04));
    foreach (st[i]) begin
      drive_step(st[i]);
      e = sb_q.pop_front();
      total++;
      if (bus.stall !== e.stall || bus.pending !== e.pend) begin
        bad++;
        $display("FAIL reset_mid step %0d: stall=%b pending=%h expected stall=%b pending=%h",
                 i, bus.stall, bus.pending, e.stall, e.pend);
      end
`ifdef HAZARD_SCOREBOARD_STALL_CNT_EN
      if (i == 2) begin
        total++;
        if (bus.stall_cnt !== 16'd0) begin
          bad++;
          $display("FAIL reset_mid stall_cnt: got %0d expected 0", bus.stall_cnt);
        end
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_multi_cycle();
    test_load_use();
    test_back_to_back();
    test_waw();
    test_flush();
    test_reset_mid();
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
